// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences a UART receiver (baud latch, enable, framing-error
// resync) and buffers completed frames in a show-ahead FIFO with error tags,
// presented to the consumer over a valid/ready handshake.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned RECOVER_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    // configuration
    input  logic        cfg_enable,
    input  logic [2:0]  cfg_baud,
    // receiver control / status
    output logic [2:0]  rx_baud_select,
    output logic        rx_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_perror,
    input  logic        rx_ferror,
    // consumer stream
    output logic [7:0]  m_data,
    output logic [1:0]  m_err,
    output logic        m_valid,
    input  logic        m_ready,
    // status
    output logic        overrun,
    input  logic        clr_overrun,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [ADDR_W:0]  FIFO_FULL    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  FIFO_ONE     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE     = ADDR_W'(1);

    typedef enum logic [1:0] {
        StDisabled,
        StSettle,
        StRun,
        StRecover
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        baud_q, baud_d;
    logic              rx_valid_q;

    // Entry layout: {ferror, perror, data[7:0]}
    logic [9:0]        mem_q [DEPTH];
    logic [9:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic detect;
    logic full;
    logic push;
    logic pop;
    logic drop;

    // Frame strobe: one per rising edge of the receiver's level valid, RUN only.
    always_comb begin
        detect = rx_valid & ~rx_valid_q & (state_q == StRun);
        full   = (count_q == FIFO_FULL);
        pop    = m_valid & m_ready;
        // A simultaneous pop frees a slot, so a full FIFO still accepts.
        push   = detect & (~full | pop);
        drop   = detect & full & ~pop;
    end

    // Receiver sequencing FSM: next state, settle/recover counter and baud latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        baud_d  = baud_q;
        unique case (state_q)
            StDisabled: begin
                if (cfg_enable) begin
                    baud_d  = cfg_baud;
                    cnt_d   = SETTLE_LOAD;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!cfg_enable) begin
                    state_d = StDisabled;
                end else if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRun: begin
                if (!cfg_enable) begin
                    state_d = StDisabled;
                end else if (detect && rx_ferror) begin
                    // Hold the receiver off long enough to lose bit sync and re-find start.
                    cnt_d   = RECOVER_LOAD;
                    state_d = StRecover;
                end
            end
            StRecover: begin
                if (!cfg_enable) begin
                    state_d = StDisabled;
                end else if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StDisabled;
        endcase
    end

    // FSM state, counter, baud latch and valid-edge history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StDisabled;
            cnt_q      <= '0;
            baud_q     <= 3'b000;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            baud_q     <= baud_d;
            rx_valid_q <= rx_valid;
        end
    end

    // FIFO next-state: write on push, advance read on pop, occupancy tracks both.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {rx_ferror, rx_perror, rx_data};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + FIFO_ONE;
        end else if (pop && !push) begin
            count_d = count_q - FIFO_ONE;
        end
    end

    // Status next-state: a drop in the same cycle as a clear keeps overrun set.
    always_comb begin
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (detect) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // FIFO storage, pointers and status registers; only reset flushes the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Outputs come from registers only, so nothing depends combinationally on m_ready.
    always_comb begin
        rx_baud_select = baud_q;
        rx_en          = (state_q == StRun);
        busy           = (state_q != StDisabled);
        m_valid        = (count_q != '0);
        m_data         = mem_q[rd_ptr_q][7:0];
        m_err          = mem_q[rd_ptr_q][9:8];
        overrun        = overrun_q;
        frame_count    = frame_count_q;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sits between the UART receiver and its consumer. It sequences the receiver: baud selection, enable, and resync after framing errors. Each completed frame is captured once into a small show-ahead FIFO, tagged with its parity and framing error flags. Frames are handed to the consumer over a valid/ready handshake, with overrun and frame-count status.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
ADDR_W, 2, log2(DEPTH)
SETTLE_CYCLES, 16, clocks rx_en held low after enable/baud latch before receiving
RECOVER_CYCLES, 64, clocks rx_en held low after a framing error

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cfg_enable  in  1  level; 1 = receiver requested on
cfg_baud  in  3  requested baud code
rx_baud_select  out  3  drives receiver baud_select
rx_en  out  1  drives receiver Rx_EN
rx_data  in  8  receiver Rx_DATA
rx_valid  in  1  receiver Rx_VALID (level, may stay high many clocks)
rx_perror  in  1  receiver Rx_PERROR
rx_ferror  in  1  receiver Rx_FERROR
m_data  out  8  head-of-FIFO byte
m_err  out  2  head-of-FIFO flags {ferror, perror}
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts head when m_valid & m_ready
overrun  out  1  sticky: frame dropped because FIFO full
clr_overrun  in  1  synchronous clear of overrun
frame_count  out  16  frames detected (stored + dropped), wraps FFFF->0000
busy  out  1  1 in any state other than DISABLED

Behaviour:
- Reset (reset=0, async): state DISABLED, rx_en=0, rx_baud_select=3'b000, FIFO empty, m_valid=0, m_data=0, m_err=0, overrun=0, frame_count=0, rx_valid_q=0, busy=0.
- FSM states:
  - DISABLED: rx_en=0. When cfg_enable=1: latch cfg_baud into rx_baud_select, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: rx_en=0. Counter decrements each clock. At 0, go to RUN. cfg_enable=0 → DISABLED.
  - RUN: rx_en=1. cfg_enable=0 → DISABLED (rx_en low the next cycle). A captured frame with rx_ferror=1 → RECOVER, with counter loaded to RECOVER_CYCLES-1.
  - RECOVER: rx_en=0. Counter decrements to 0 → RUN. cfg_enable=0 → DISABLED.
- rx_baud_select changes only on the DISABLED→SETTLE transition. Changes to cfg_baud while busy are ignored until the next enable.
- Frame detect: rx_valid_q is a registered copy of rx_valid. A frame is detected when rx_valid & ~rx_valid_q & state==RUN. At most one frame per rising edge of rx_valid. Edges seen outside RUN are ignored and not counted.
- On detect at cycle N:
  - frame_count increments, taking effect at cycle N+1.
  - If the FIFO is not full, or a pop occurs in the same cycle, {rx_ferror, rx_perror, rx_data} is written. The FIFO is then non-empty, so m_valid=1 from cycle N+1.
  - Otherwise the frame is dropped and overrun is set.
- FIFO: show-ahead, so m_data/m_err always reflect the head. Pop on m_valid & m_ready.
  - Push and pop in the same cycle: the count is unchanged, both accepted (including when full).
  - Pop when empty: no effect.
  - Pointers wrap modulo DEPTH.
  - When empty, m_data/m_err hold their last value and are don't-care.
- overrun: a set event wins over clr_overrun in the same cycle.
- The FIFO contents survive transitions to DISABLED and stay drainable. Only reset flushes them.
- m_valid/m_data must not depend combinationally on m_ready.

Test Plan:
- Reset, cfg_baud=3'b101, cfg_enable=1 → rx_baud_select=101 next cycle, rx_en=0 for 16 clocks, then rx_en=1; busy=1 throughout.
- In RUN, rx_data=8'hA5, rx_valid held high 10 clocks → exactly one entry, m_data=A5, m_err=00, frame_count=1; consumer pulses m_ready → m_valid=0.
- m_ready=0, 5 frames 01..05 → FIFO holds 01..04, overrun=1, frame_count=5. Frame 06 arriving together with a pop when full is stored. Drain order is 01,02,03,04,06.
- Frame with rx_ferror=1, rx_data=3C → stored with m_err=10, rx_en=0 for exactly 64 clocks, then returns to RUN. A rx_valid edge during RECOVER is neither stored nor counted.
- cfg_enable dropped in RUN with 2 entries queued → rx_en=0 next cycle, busy=0, both entries still drain. Changing cfg_baud while busy has no effect.
- Assert reset mid-RECOVER with FIFO non-empty → immediately m_valid=0, rx_en=0, overrun=0, frame_count=0, state DISABLED.
